// File: rtl/qei_multi.sv
// Purpose: N-channel quadrature encoder interface. Each channel synchronises and
// glitch-filters A/B/Z, decodes x4 quadrature into a wrapping position counter,
// captures the count on Z rising edges (with optional clear), flags illegal
// double-bit transitions, and measures signed steps per fixed velocity window.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   enc_a/enc_b/enc_z   raw encoder pins, one bit per channel
//   index_clr_en        per channel: a Z rising edge zeroes the count
//   count_load          per channel 1-cycle strobe: count <= load_value
//   load_value          shared load value
//   err_clr             per channel 1-cycle strobe: clear the error flag
//   count_out           position counts, channel i at [i*COUNT_W +: COUNT_W]
//   index_pos           count captured at the last Z rising edge
//   index_seen          sticky, set by the first Z rising edge
//   err                 sticky illegal-transition flag
//   vel_out             signed saturated steps per window, [i*VEL_W +: VEL_W]
//   vel_valid           1-cycle pulse when vel_out updates
module qei_multi #(
   parameter int unsigned NUM_CH     = 3,
   parameter int unsigned COUNT_W    = 32,
   parameter int unsigned FILT_LEN   = 8,
   parameter int unsigned VEL_PERIOD = 50000,
   parameter int unsigned VEL_W      = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           enc_a,
   input  logic [NUM_CH-1:0]           enc_b,
   input  logic [NUM_CH-1:0]           enc_z,
   input  logic [NUM_CH-1:0]           index_clr_en,
   input  logic [NUM_CH-1:0]           count_load,
   input  logic [COUNT_W-1:0]          load_value,
   input  logic [NUM_CH-1:0]           err_clr,
   output logic [NUM_CH*COUNT_W-1:0]   count_out,
   output logic [NUM_CH*COUNT_W-1:0]   index_pos,
   output logic [NUM_CH-1:0]           index_seen,
   output logic [NUM_CH-1:0]           err,
   output logic [NUM_CH*VEL_W-1:0]     vel_out,
   output logic                        vel_valid
);

   localparam int unsigned FC_W    = 8;
   localparam int unsigned WIN_W   = (VEL_PERIOD > 2) ? $clog2(VEL_PERIOD) : 1;
   localparam int unsigned PRIME_W = 9;

   localparam logic signed [VEL_W:0] VMAX = {2'b00, {(VEL_W-1){1'b1}}};
   localparam logic signed [VEL_W:0] VMIN = {2'b11, {(VEL_W-1){1'b0}}};

   // Shared window counter, startup priming timer and velocity strobe
   logic [WIN_W-1:0]   win_q, win_d;
   logic               win_end;
   logic [PRIME_W-1:0] prime_cnt_q, prime_cnt_d;
   logic [NUM_CH-1:0]  primed_q, primed_d;
   logic               vel_valid_q, vel_valid_d;

   // Priming waits until the filtered inputs and their one-cycle history both
   // reflect the pins, so the first real state is adopted without decoding.
   always_comb begin : shared_comb
      win_end     = (win_q == WIN_W'(VEL_PERIOD - 1));
      win_d       = win_end ? '0 : win_q + WIN_W'(1);
      prime_cnt_d = prime_cnt_q;
      primed_d    = primed_q;
      if (!(&primed_q)) prime_cnt_d = prime_cnt_q + PRIME_W'(1);
      if (prime_cnt_q == PRIME_W'(FILT_LEN + 2)) primed_d = '1;
      vel_valid_d = win_end;
   end

   always_ff @(posedge clk) begin : shared_ff
      if (reset) begin
         win_q       <= '0;
         prime_cnt_q <= '0;
         primed_q    <= '0;
         vel_valid_q <= 1'b0;
      end else begin
         win_q       <= win_d;
         prime_cnt_q <= prime_cnt_d;
         primed_q    <= primed_d;
         vel_valid_q <= vel_valid_d;
      end
   end

   assign vel_valid = vel_valid_q;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Bit order in the 3-bit vectors: {z, b, a}
      logic [2:0]               raw, s1_q, s1_d, s2_q, s2_d, filt_q, filt_d;
      logic [2:0][FC_W-1:0]     fc_q, fc_d;
      logic [1:0]               ab_cur, ab_prev_q, ab_prev_d;
      logic                     z_prev_q, z_prev_d;
      logic [COUNT_W-1:0]       count_q, count_d, ipos_q, ipos_d, count_step;
      logic                     seen_q, seen_d, err_q, err_d;
      logic signed [VEL_W:0]    acc_q, acc_d, acc_sum, acc_sat;
      logic signed [VEL_W-1:0]  vel_q, vel_d;
      logic signed [1:0]        step;
      logic                     illegal, z_rise;

      assign raw = {enc_z[i], enc_b[i], enc_a[i]};

      // Synchroniser plus run-length filter on each of A, B, Z
      always_comb begin : filter_comb
         s1_d   = raw;
         s2_d   = s1_q;
         filt_d = filt_q;
         fc_d   = fc_q;
         for (int k = 0; k < 3; k++) begin
            if (s2_q[k] == filt_q[k]) begin
               fc_d[k] = '0;
            end else if (fc_q[k] == FC_W'(FILT_LEN - 1)) begin
               filt_d[k] = s2_q[k];
               fc_d[k]   = '0;
            end else begin
               fc_d[k] = fc_q[k] + FC_W'(1);
            end
         end
      end

      // x4 decode on {A,B}: 00->10->11->01->00 counts up
      always_comb begin : decode_comb
         ab_cur  = {filt_q[0], filt_q[1]};
         step    = 2'sd0;
         illegal = 1'b0;
         if (primed_q[i]) begin
            case ({ab_prev_q, ab_cur})
               4'b0010, 4'b1011, 4'b1101, 4'b0100: step = 2'sd1;
               4'b1000, 4'b1110, 4'b0111, 4'b0001: step = -2'sd1;
               4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
               default: step = 2'sd0;
            endcase
         end
         z_rise = primed_q[i] & filt_q[2] & ~z_prev_q;
      end

      // Count, index capture, error and velocity accumulation
      always_comb begin : count_comb
         ab_prev_d  = ab_cur;
         z_prev_d   = filt_q[2];
         count_step = count_q + {{(COUNT_W-2){step[1]}}, step};
         count_d    = count_step;
         if (count_load[i])                    count_d = load_value;
         else if (z_rise && index_clr_en[i])   count_d = '0;
         ipos_d = z_rise ? count_step : ipos_q;
         seen_d = seen_q | z_rise;
         err_d  = err_clr[i] ? 1'b0 : err_q;
         if (illegal) err_d = 1'b1;
         // acc_q always stays within VEL_W range, so one step never overflows VEL_W+1
         acc_sum = acc_q + $signed({{(VEL_W-1){step[1]}}, step});
         if (acc_sum > VMAX)      acc_sat = VMAX;
         else if (acc_sum < VMIN) acc_sat = VMIN;
         else                     acc_sat = acc_sum;
         acc_d = win_end ? '0 : acc_sat;
         vel_d = win_end ? acc_sat[VEL_W-1:0] : vel_q;
      end

      always_ff @(posedge clk) begin : ch_ff
         if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            filt_q    <= '0;
            fc_q      <= '0;
            ab_prev_q <= '0;
            z_prev_q  <= 1'b0;
            count_q   <= '0;
            ipos_q    <= '0;
            seen_q    <= 1'b0;
            err_q     <= 1'b0;
            acc_q     <= '0;
            vel_q     <= '0;
         end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            filt_q    <= filt_d;
            fc_q      <= fc_d;
            ab_prev_q <= ab_prev_d;
            z_prev_q  <= z_prev_d;
            count_q   <= count_d;
            ipos_q    <= ipos_d;
            seen_q    <= seen_d;
            err_q     <= err_d;
            acc_q     <= acc_d;
            vel_q     <= vel_d;
         end
      end

      assign count_out[i*COUNT_W +: COUNT_W] = count_q;
      assign index_pos[i*COUNT_W +: COUNT_W] = ipos_q;
      assign index_seen[i]                   = seen_q;
      assign err[i]                          = err_q;
      assign vel_out[i*VEL_W +: VEL_W]       = vel_q;
   end

endmodule

// File: tb/tb_qei_multi.sv
// Bench for qei_multi: randomized and directed stimulus checked every cycle
// against a behavioural model, plus literal expectations for key scenarios.
module tb_qei_multi;

   localparam int unsigned NC = 3;
   localparam int unsigned CW = 32;
   localparam int unsigned FL = 8;
   localparam int unsigned VP = 1000;
   localparam int unsigned VW = 7;
   localparam int VMAXI = 63;
   localparam int VMINI = -64;

   logic clk = 1'b0;
   logic reset;
   logic [NC-1:0] enc_a, enc_b, enc_z, index_clr_en, count_load, err_clr;
   logic [CW-1:0] load_value;
   logic [NC*CW-1:0] count_out, index_pos;
   logic [NC-1:0] index_seen, err;
   logic [NC*VW-1:0] vel_out;
   logic vel_valid;

   qei_multi #(.NUM_CH(NC), .COUNT_W(CW), .FILT_LEN(FL), .VEL_PERIOD(VP), .VEL_W(VW)) dut (
      .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
      .index_clr_en(index_clr_en), .count_load(count_load), .load_value(load_value),
      .err_clr(err_clr), .count_out(count_out), .index_pos(index_pos),
      .index_seen(index_seen), .err(err), .vel_out(vel_out), .vel_valid(vel_valid));

   always #5 clk = ~clk;

   // Next-cycle input values, applied by tick()
   logic n_reset;
   logic [NC-1:0] n_a, n_b, n_z, n_clr_en, n_load, n_eclr;
   logic [CW-1:0] n_lv;
   int ph [NC];

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   // Model state: raw pins delayed, recent filter samples, filtered history
   bit rd1 [NC][3];
   bit rd2 [NC][3];
   bit hist [NC][3][FL];
   bit f1 [NC][3];
   bit f2 [NC][3];
   int unsigned edge_n;
   logic [CW-1:0] m_cnt [NC];
   logic [CW-1:0] m_ipos [NC];
   bit m_seen [NC];
   bit m_err [NC];
   int m_acc [NC];
   int m_vel [NC];
   bit m_vv;

   task automatic chk(input int ch, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s ch%0d actual=%0h required=%0h t=%0t", name, ch, act, exp, $time);
   endtask

   // Gray phase of {A,B}: 00=0, 10=1, 11=2, 01=3
   function automatic int phase(bit a, bit b);
      return a ? (b ? 2 : 1) : (b ? 3 : 0);
   endfunction

   // Advance the model by one clock edge using the inputs just applied
   task automatic model_step();
      int st, d;
      bit ill, zr, all_diff;
      bit rw [3];
      logic [CW-1:0] stepped;
      if (reset) begin
         for (int c = 0; c < NC; c++) begin
            for (int k = 0; k < 3; k++) begin
               rd1[c][k] = 0; rd2[c][k] = 0; f1[c][k] = 0; f2[c][k] = 0;
               for (int j = 0; j < FL; j++) hist[c][k][j] = 0;
            end
            m_cnt[c] = '0; m_ipos[c] = '0; m_seen[c] = 0; m_err[c] = 0;
            m_acc[c] = 0; m_vel[c] = 0;
         end
         edge_n = 0;
         m_vv = 0;
         return;
      end
      edge_n++;
      for (int c = 0; c < NC; c++) begin
         st = 0; ill = 0; zr = 0;
         if (edge_n >= FL + 4) begin
            d = (phase(f1[c][0], f1[c][1]) - phase(f2[c][0], f2[c][1])) & 3;
            if (d == 1) st = 1;
            else if (d == 3) st = -1;
            else if (d == 2) ill = 1;
            zr = f1[c][2] && !f2[c][2];
         end
         stepped = m_cnt[c] + CW'(st);
         if (zr) begin
            m_ipos[c] = stepped;
            m_seen[c] = 1;
         end
         if (count_load[c]) m_cnt[c] = load_value;
         else if (zr && index_clr_en[c]) m_cnt[c] = '0;
         else m_cnt[c] = stepped;
         if (ill) m_err[c] = 1;
         else if (err_clr[c]) m_err[c] = 0;
         m_acc[c] = m_acc[c] + st;
         if (m_acc[c] > VMAXI) m_acc[c] = VMAXI;
         if (m_acc[c] < VMINI) m_acc[c] = VMINI;
         if (edge_n % VP == 0) begin
            m_vel[c] = m_acc[c];
            m_acc[c] = 0;
         end
         rw[0] = enc_a[c]; rw[1] = enc_b[c]; rw[2] = enc_z[c];
         for (int k = 0; k < 3; k++) begin
            for (int j = FL - 1; j > 0; j--) hist[c][k][j] = hist[c][k][j-1];
            hist[c][k][0] = rd2[c][k];
            all_diff = 1;
            for (int j = 0; j < FL; j++) if (hist[c][k][j] == f1[c][k]) all_diff = 0;
            f2[c][k] = f1[c][k];
            if (all_diff) f1[c][k] = !f1[c][k];
            rd2[c][k] = rd1[c][k];
            rd1[c][k] = rw[k];
         end
      end
      m_vv = (edge_n % VP == 0);
   endtask

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      logic [VW-1:0] ev;
      if (chk_en) begin
         for (int c = 0; c < NC; c++) begin
            ev = VW'(m_vel[c]);
            chk(c, "count", count_out[c*CW +: CW], m_cnt[c]);
            chk(c, "index_pos", index_pos[c*CW +: CW], m_ipos[c]);
            chk(c, "index_seen", index_seen[c], m_seen[c]);
            chk(c, "err", err[c], m_err[c]);
            chk(c, "vel", vel_out[c*VW +: VW], ev);
         end
         chk(0, "vel_valid", vel_valid, m_vv);
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
      reset = n_reset; enc_a = n_a; enc_b = n_b; enc_z = n_z;
      index_clr_en = n_clr_en; count_load = n_load; load_value = n_lv; err_clr = n_eclr;
      model_step();
      chk_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic set_ph(input int c, input int p);
      ph[c] = p & 3;
      n_a[c] = (ph[c] == 1) || (ph[c] == 2);
      n_b[c] = (ph[c] == 2) || (ph[c] == 3);
   endtask

   task automatic move(input int c, input int dir, input int hold);
      set_ph(c, ph[c] + dir);
      ticks(hold);
   endtask

   task automatic wait_vv();
      bit found = 0;
      for (int k = 0; k < VP + 100 && !found; k++) begin
         tick();
         found = vel_valid;
      end
      chk(0, "vel_valid_timeout", found, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      n_reset = 1; n_a = '0; n_b = '0; n_z = '0; n_clr_en = '0; n_load = '0; n_eclr = '0; n_lv = '0;
      for (int c = 0; c < NC; c++) ph[c] = 0;
      set_ph(0, 2);
      reset = 1; enc_a = n_a; enc_b = n_b; enc_z = '0; index_clr_en = '0;
      count_load = '0; load_value = '0; err_clr = '0;
      ticks(3);
      chk(0, "rst_count", count_out, '0);
      chk(0, "rst_vel_valid", vel_valid, 0);

      // Priming with A=B=1 held on ch0
      n_reset = 0;
      ticks(11);
      chk(0, "prime_count", count_out[0 +: CW], 0);
      chk(0, "prime_err", err, 0);
      ticks(20);

      // Forward 16 edges then reverse 17 on ch1
      for (int i = 0; i < 16; i++) move(1, 1, 20);
      chk(1, "fwd16", count_out[CW +: CW], 16);
      for (int i = 0; i < 17; i++) move(1, -1, 20);
      chk(1, "rev17_wrap", count_out[CW +: CW], 32'hFFFF_FFFF);

      // Glitches on ch0 A: 7 cycles rejected, 8 cycles accepted and undone
      n_a[0] = 0; ticks(7); n_a[0] = 1; ticks(20);
      chk(0, "glitch7", count_out[0 +: CW], 0);
      n_a[0] = 0; ticks(8); n_a[0] = 1; ticks(3);
      chk(0, "glitch8_mid", count_out[0 +: CW], 1);
      ticks(20);
      chk(0, "glitch8_end", count_out[0 +: CW], 0);

      // Illegal transitions on ch2
      set_ph(2, 2); ticks(20);
      chk(2, "illegal_err", err[2], 1);
      chk(2, "illegal_count", count_out[2*CW +: CW], 0);
      n_eclr[2] = 1; tick(); n_eclr[2] = 0;
      chk(2, "err_clr", err[2], 0);
      set_ph(2, 0); ticks(10);
      n_eclr[2] = 1; tick(); n_eclr[2] = 0;
      chk(2, "err_set_wins", err[2], 1);
      ticks(5);
      n_eclr[2] = 1; tick(); n_eclr[2] = 0;
      chk(2, "err_clr2", err[2], 0);

      // Index on ch0: capture and clear
      n_lv = 100; n_load[0] = 1; tick(); n_load[0] = 0;
      chk(0, "load100", count_out[0 +: CW], 100);
      n_clr_en[0] = 1; n_z[0] = 1; ticks(10);
      chk(0, "seen_before", index_seen[0], 0);
      tick();
      chk(0, "ipos100", index_pos[0 +: CW], 100);
      chk(0, "idx_clear", count_out[0 +: CW], 0);
      chk(0, "seen_after", index_seen[0], 1);
      n_z[0] = 0; ticks(20);
      n_lv = 200; n_load[0] = 1; tick(); n_load[0] = 0;
      n_z[0] = 1; set_ph(0, ph[0] + 1); ticks(11);
      chk(0, "ipos_step", index_pos[0 +: CW], 201);
      chk(0, "idx_clear2", count_out[0 +: CW], 0);
      n_z[0] = 0; ticks(20);
      n_z[0] = 1; ticks(10);
      n_lv = 500; n_load[0] = 1; tick(); n_load[0] = 0;
      chk(0, "load_beats_clr", count_out[0 +: CW], 500);
      chk(0, "ipos_zero", index_pos[0 +: CW], 0);
      n_clr_en[0] = 0; n_z[0] = 0; ticks(20);

      // Velocity on ch1
      wait_vv();
      ticks(20);
      for (int i = 0; i < 37; i++) move(1, 1, 20);
      wait_vv();
      chk(1, "vel37", vel_out[VW +: VW], 7'd37);
      ticks(10);
      for (int i = 0; i < 80; i++) move(1, 1, 10);
      wait_vv();
      chk(1, "vel_sat_max", vel_out[VW +: VW], 7'd63);
      ticks(10);
      for (int i = 0; i < 80; i++) move(1, -1, 10);
      wait_vv();
      chk(1, "vel_sat_min", vel_out[VW +: VW], 7'h40);

      // Mid-operation reset and first vel_valid timing
      set_ph(1, 0);
      n_reset = 1; ticks(2); n_reset = 0;
      ticks(VP - 1);
      chk(0, "first_vv_early", vel_valid, 0);
      tick();
      chk(0, "first_vv", vel_valid, 1);

      // Random traffic with a reset in the middle
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int c = 0; c < NC; c++) begin
            if ($urandom_range(0, 15) == 0) n_a[c] = ~n_a[c];
            if ($urandom_range(0, 15) == 0) n_b[c] = ~n_b[c];
            if ($urandom_range(0, 39) == 0) n_z[c] = ~n_z[c];
            if ($urandom_range(0, 99) == 0) n_clr_en[c] = ~n_clr_en[c];
            n_load[c] = ($urandom_range(0, 63) == 0);
            n_eclr[c] = ($urandom_range(0, 31) == 0);
         end
         n_lv = $urandom;
         n_reset = (cyc >= 2000 && cyc < 2002);
         tick();
      end
      n_load = '0; n_eclr = '0;
      ticks(2);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
